rv32_data_mem_responder: RTL and testbench

RV32_DATA_MEM_RESPONDER -- requirements
Module: rv32_data_mem_responder

---
 rtl/rv32_data_mem_responder_pkg.sv | 21 ++
 rtl/rv32_data_ram_sp.sv | 31 +++
 rtl/rv32_data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_rv32_data_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_data_mem_responder_pkg.sv
// Shared definitions for the RV32 data-memory responder: FSM encoding,
// MMIO register offsets within the 16-byte window, STATUS bit positions.
// Ports: none (package only).
package rv32_data_mem_responder_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int MMIO_WINDOW_BYTES = 16;

    localparam logic [3:0] MMIO_OFS_LED    = 4'h0;
    localparam logic [3:0] MMIO_OFS_CYCLE  = 4'h4;
    localparam logic [3:0] MMIO_OFS_STATUS = 4'h8;

    localparam int STATUS_BIT_MISALIGN = 0;
    localparam int STATUS_BIT_RANGE    = 1;
    localparam int STATUS_BIT_BUSY     = 2;

endpackage

// File: rtl/rv32_data_ram_sp.sv
// Single-port 32-bit RAM: synchronous write, registered read, no reset.
// Latency: read data valid one clk after re_i; holds until the next re_i.
// Ports: clk, we_i/re_i strobes, addr_i word index, wdata_i, rdata_o.
module rv32_data_ram_sp #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Non-blocking read of mem_q gives read-before-write on a shared edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_data_mem_responder.sv
// CPU data-memory responder: RAM + MMIO window (LED, CYCLE, STATUS), with a
// power-up clear sweep. Reads return one clk after sampling; no backpressure,
// accesses arriving during the sweep are dropped.
// Ports: clk/rst_n, CPU request (enable/read/addr/wdata), read_data, led,
// init_busy and the sticky error flags.
module rv32_data_mem_responder
    import rv32_data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_mem_enable,
    input  logic        data_mem_read,
    input  logic [31:0] data_addr_bus,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [15:0] led,
    output logic        init_busy,
    output logic        err_misalign,
    output logic        err_range
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS * 4);
    localparam logic [32:0] MMIO_LO   = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_HI   = MMIO_LO + 33'(MMIO_WINDOW_BYTES);

    state_e         state_q, state_d;
    logic [AW-1:0]  clr_idx_q, clr_idx_d;
    logic [31:0]    cycle_q;
    logic [15:0]    led_q, led_d;
    logic           mis_q, mis_d;
    logic           rng_q, rng_d;
    // read_data is a mux of the RAM's own output register and a local MMIO
    // read register, so both paths keep the same one-cycle latency.
    logic           sel_ram_q, sel_ram_d;
    logic [31:0]    mmio_rdata_q, mmio_rdata_d;

    logic           ram_we, ram_re;
    logic [AW-1:0]  ram_addr;
    logic [31:0]    ram_wdata, ram_rdata;

    logic [31:0]    addr_al;
    logic [32:0]    addr_ext;
    logic           hit_ram, hit_mmio;
    logic [3:0]     mmio_ofs;

    // Misaligned accesses are carried out at the enclosing word.
    assign addr_al  = {data_addr_bus[31:2], 2'b00};
    assign addr_ext = {1'b0, addr_al};
    assign hit_ram  = addr_ext < RAM_BYTES;
    assign hit_mmio = (addr_ext >= MMIO_LO) && (addr_ext < MMIO_HI);
    assign mmio_ofs = addr_al[3:0] - MMIO_BASE[3:0];

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        led_d        = led_q;
        mis_d        = mis_q;
        rng_d        = rng_q;
        sel_ram_d    = sel_ram_q;
        mmio_rdata_d = mmio_rdata_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = data_addr_bus[AW+1:2];
        ram_wdata    = write_data;

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_idx_q;
                ram_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (data_mem_enable) begin
                    if (data_mem_read) begin
                        if (hit_ram) begin
                            ram_re    = 1'b1;
                            sel_ram_d = 1'b1;
                        end else begin
                            sel_ram_d    = 1'b0;
                            mmio_rdata_d = '0;
                            if (hit_mmio) begin
                                case (mmio_ofs)
                                    MMIO_OFS_LED:    mmio_rdata_d = {16'h0, led_q};
                                    MMIO_OFS_CYCLE:  mmio_rdata_d = cycle_q;
                                    MMIO_OFS_STATUS: begin
                                        mmio_rdata_d[STATUS_BIT_MISALIGN] = mis_q;
                                        mmio_rdata_d[STATUS_BIT_RANGE]    = rng_q;
                                        mmio_rdata_d[STATUS_BIT_BUSY]     = init_busy;
                                    end
                                    default:         mmio_rdata_d = '0;
                                endcase
                            end
                        end
                    end else begin
                        if (hit_ram) begin
                            ram_we = 1'b1;
                        end else if (hit_mmio) begin
                            case (mmio_ofs)
                                MMIO_OFS_LED: led_d = write_data[15:0];
                                MMIO_OFS_STATUS: begin
                                    if (write_data[STATUS_BIT_MISALIGN]) mis_d = 1'b0;
                                    if (write_data[STATUS_BIT_RANGE])    rng_d = 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    // Placed after the W1C handling so a same-edge set wins.
                    if (data_addr_bus[1:0] != 2'b00) mis_d = 1'b1;
                    if (!hit_ram && !hit_mmio)       rng_d = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            led_q        <= '0;
            mis_q        <= 1'b0;
            rng_q        <= 1'b0;
            sel_ram_q    <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            led_q        <= led_d;
            mis_q        <= mis_d;
            rng_q        <= rng_d;
            sel_ram_q    <= sel_ram_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    rv32_data_ram_sp #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign read_data    = sel_ram_q ? ram_rdata : mmio_rdata_q;
    assign led          = led_q;
    assign init_busy    = (state_q == ST_CLEAR);
    assign err_misalign = mis_q;
    assign err_range    = rng_q;

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Directed bench for rv32_data_mem_responder (default parameters).
// Latency: each access task spans one clk; results sampled on the falling edge.
// Backpressure: none; the bench waits out the clear sweep with a bounded loop.
module tb_rv32_data_mem_responder;

    localparam logic [31:0] MB = 32'hFFFF_FF00;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic [15:0] led;
    logic        init_busy;
    logic        err_misalign;
    logic        err_range;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc_model;

    rv32_data_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_mem_enable(en),
        .data_mem_read  (rd),
        .data_addr_bus  (addr),
        .write_data     (wdata),
        .read_data      (read_data),
        .led            (led),
        .init_busy      (init_busy),
        .err_misalign   (err_misalign),
        .err_range      (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_model <= 32'd0;
        else        cyc_model <= cyc_model + 32'd1;
    end

    // Called at a falling edge; returns at the falling edge after sampling.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r);
        en    = 1'b1;
        rd    = r;
        addr  = a;
        wdata = d;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!init_busy) break;
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        en = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h want %h", read_data, 32'h0); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", init_busy); end
        checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", err_misalign); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL reset_range: got %b want 0", err_range); end
        rst_n = 1'b1;
        // Drive accesses during the sweep; all must be ignored.
        en = 1'b1; rd = 1'b1; addr = MB + 32'h4;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 5) begin rd = 1'b0; addr = MB + 32'h1; wdata = 32'hFFFF; end
            if (n == 10) en = 1'b0;
            if (!init_busy) break;
        end
        checks++; if (n !== 256) begin errors++; $display("FAIL sweep_len: got %0d want 256", n); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL clear_ignore_led: got %h want 0000", led); end
        checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL clear_ignore_mis: got %b want 0", err_misalign); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL clear_ignore_rd: got %h want 0", read_data); end
        access(MB + 32'h8, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL status_ready: got %h want 0", read_data); end
        access(32'h3FC, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL ram_3fc_zero: got %h want 0", read_data); end
    endtask

    task automatic test_ram;
        access(32'h10, 32'hDEADBEEF, 1'b0);
        access(32'h10, 32'h0, 1'b1);
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rw: got %h want deadbeef", read_data); end
    endtask

    task automatic test_back_to_back;
        access(32'h20, 32'h11111111, 1'b0);
        access(32'h24, 32'h22222222, 1'b0);
        access(32'h20, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h11111111) begin errors++; $display("FAIL b2b_rd0: got %h want 11111111", read_data); end
        access(32'h24, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h22222222) begin errors++; $display("FAIL b2b_rd1: got %h want 22222222", read_data); end
        repeat (3) @(negedge clk);
        checks++; if (read_data !== 32'h22222222) begin errors++; $display("FAIL hold_idle: got %h want 22222222", read_data); end
        access(32'h20, 32'h33333333, 1'b0);
        checks++; if (read_data !== 32'h22222222) begin errors++; $display("FAIL hold_write: got %h want 22222222", read_data); end
        access(32'h20, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h33333333) begin errors++; $display("FAIL b2b_wr_rd: got %h want 33333333", read_data); end
    endtask

    task automatic test_led;
        access(MB, 32'h0001ABCD, 1'b0);
        checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_write: got %h want abcd", led); end
        access(MB, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0000ABCD) begin errors++; $display("FAIL led_read: got %h want 0000abcd", read_data); end
    endtask

    task automatic test_misalign;
        access(32'h13, 32'h0, 1'b1);
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_read: got %h want deadbeef", read_data); end
        checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", err_misalign); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL mis_range: got %b want 0", err_range); end
        access(MB + 32'h8, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL mis_status: got %h want 1", read_data); end
        access(MB + 32'h8, 32'h1, 1'b0);
        checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", err_misalign); end
        access(32'h17, 32'hCAFEF00D, 1'b0);
        access(32'h14, 32'h0, 1'b1);
        checks++; if (read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_write: got %h want cafef00d", read_data); end
        access(MB + 32'h8, 32'h1, 1'b0);
    endtask

    task automatic test_range;
        access(32'h0, 32'h0BADC0DE, 1'b0);
        access(32'h8000, 32'h12345678, 1'b0);
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL rng_flag: got %b want 1", err_range); end
        access(32'h0, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0BADC0DE) begin errors++; $display("FAIL rng_ram_kept: got %h want 0badc0de", read_data); end
        access(32'h8000, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rng_read: got %h want 0", read_data); end
        access(MB + 32'h8, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h2) begin errors++; $display("FAIL rng_status: got %h want 2", read_data); end
    endtask

    task automatic test_set_wins;
        // Misaligned W1C of both flags: range clears, misalign is re-set.
        access(MB + 32'h9, 32'h3, 1'b0);
        checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL setwin_mis: got %b want 1", err_misalign); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL setwin_rng: got %b want 0", err_range); end
        access(MB + 32'h8, 32'h1, 1'b0);
        checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL setwin_clear: got %b want 0", err_misalign); end
    endtask

    task automatic test_mmio_misc;
        access(MB + 32'h4, 32'h0, 1'b0);
        access(MB + 32'h4, 32'h0, 1'b1);
        checks++; if (read_data !== cyc_model - 32'd1) begin errors++; $display("FAIL cycle_read: got %h want %h", read_data, cyc_model - 32'd1); end
        access(MB + 32'hC, 32'hFFFFFFFF, 1'b0);
        access(MB + 32'hC, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want 0", read_data); end
        checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_kept: got %h want abcd", led); end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", init_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL mid_led: got %h want 0000", led); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL mid_rd: got %h want 0", read_data); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL mid_sweep_len: got %0d want 256", n); end
        access(32'h10, 32'h0, 1'b1);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL mid_ram_zero: got %h want 0", read_data); end
        access(MB + 32'h4, 32'h0, 1'b1);
        checks++; if (read_data !== cyc_model - 32'd1) begin errors++; $display("FAIL mid_cycle: got %h want %h", read_data, cyc_model - 32'd1); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_back_to_back;
        test_led;
        test_misalign;
        test_range;
        test_set_wins;
        test_mmio_misc;
        test_reset_mid_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
